// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master with multi-word chip-select transactions
// Byte-level valid/ready upstream; SCLK, CS and MOSI are registered outputs.
module spi_master_ctrl #(
   parameter int SHIFT_REG_WIDTH   = 8,
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int MAX_BYTES_PER_CS  = 4,
   parameter int CS_INACTIVE_CLKS  = 2
) (
   input  logic                                  i_Clk,
   input  logic                                  i_Rst,
   input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_Tx_Count,
   input  logic [SHIFT_REG_WIDTH-1:0]            i_Tx_Byte,
   input  logic                                  i_Tx_DV,
   output logic                                  o_Tx_Ready,
   output logic                                  o_Rx_DV,
   output logic [SHIFT_REG_WIDTH-1:0]            o_Rx_Byte,
   output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_Rx_Count,
   output logic                                  o_SPI_Clk,
   input  logic                                  i_SPI_Miso,
   output logic                                  o_SPI_Mosi,
   output logic                                  o_SPI_CSLow
);
   localparam int W  = SHIFT_REG_WIDTH;
   localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
   localparam int HW = $clog2(CLKS_PER_HALF_BIT + 1);
   localparam int EW = $clog2(2 * W + 1);
   localparam int SW = $clog2(CS_INACTIVE_CLKS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, BYTE_WAIT, CS_INACTIVE} state_t;

   state_t        r_state;
   logic [W-1:0]  r_tx_shift;
   logic [W-1:0]  r_rx_shift;
   logic [CW-1:0] r_count;
   logic [HW-1:0] r_half_cnt;
   logic [EW-1:0] r_edge_cnt;
   logic [SW-1:0] r_cs_cnt;
   logic          r_load;

   logic w_accept;
   logic w_count_ok;
   logic w_half_done;
   logic w_last_edge;

   assign w_accept    = i_Tx_DV && o_Tx_Ready;
   assign w_count_ok  = (i_Tx_Count != '0) && (i_Tx_Count <= CW'(MAX_BYTES_PER_CS));
   assign w_half_done = (r_half_cnt == HW'(CLKS_PER_HALF_BIT - 1));
   assign w_last_edge = (r_edge_cnt == EW'(2 * W - 1));

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state     <= IDLE;
         o_SPI_CSLow <= 1'b1;
         o_SPI_Clk   <= 1'b0;
         o_SPI_Mosi  <= 1'b0;
         o_Tx_Ready  <= 1'b0;
         o_Rx_DV     <= 1'b0;
         o_Rx_Byte   <= '0;
         o_Rx_Count  <= '0;
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_count     <= '0;
         r_half_cnt  <= '0;
         r_edge_cnt  <= '0;
         r_cs_cnt    <= '0;
         r_load      <= 1'b0;
      end else begin
         o_Rx_DV <= 1'b0;
         case (r_state)
            IDLE: begin
               o_SPI_CSLow <= 1'b1;
               o_Tx_Ready  <= 1'b1;
               // An out-of-range count swallows the word and leaves ready high
               if (w_accept && w_count_ok) begin
                  r_tx_shift <= i_Tx_Byte;
                  r_count    <= i_Tx_Count;
                  o_Rx_Count <= '0;
                  o_Tx_Ready <= 1'b0;
                  r_load     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (r_load) begin
                  r_load      <= 1'b0;
                  o_SPI_CSLow <= 1'b0;
                  o_SPI_Mosi  <= r_tx_shift[W-1];
                  r_half_cnt  <= '0;
                  r_edge_cnt  <= '0;
               end else if (w_half_done) begin
                  r_half_cnt <= '0;
                  r_edge_cnt <= r_edge_cnt + 1'b1;
                  o_SPI_Clk  <= ~o_SPI_Clk;
                  if (!o_SPI_Clk) begin
                     r_rx_shift <= {r_rx_shift[W-2:0], i_SPI_Miso};
                  end else if (w_last_edge) begin
                     o_Rx_Byte  <= r_rx_shift;
                     o_Rx_DV    <= 1'b1;
                     o_Rx_Count <= o_Rx_Count + 1'b1;
                     if (o_Rx_Count + 1'b1 < r_count) begin
                        o_Tx_Ready <= 1'b1;
                        r_state    <= BYTE_WAIT;
                     end else begin
                        r_cs_cnt <= '0;
                        r_state  <= CS_INACTIVE;
                     end
                  end else begin
                     o_SPI_Mosi <= r_tx_shift[W-2];
                     r_tx_shift <= r_tx_shift << 1;
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + 1'b1;
               end
            end
            BYTE_WAIT: begin
               if (w_accept) begin
                  r_tx_shift <= i_Tx_Byte;
                  o_Tx_Ready <= 1'b0;
                  r_load     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            CS_INACTIVE: begin
               o_SPI_CSLow <= 1'b1;
               o_SPI_Mosi  <= 1'b0;
               if (r_cs_cnt == SW'(CS_INACTIVE_CLKS)) begin
                  o_Tx_Ready <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_cs_cnt <= r_cs_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
